// File: rtl/riscv_pkg.sv
// Shared core definitions: reset PC, bubble encoding,
// fetch FSM states and the IF/ID bundle.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN,
    HELD,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect load has priority over +4 advance.
// Arithmetic wraps modulo 2^32.
module pc_reg #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= target;
    end else if (advance) begin
      pc_q <= pc_q + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem request, hold buffer,
// squash FSM for in-flight redirects, and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        busywait_IF_ID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  output logic [31:0] instruction,
  output logic [31:0] pc_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID
);

  import riscv_pkg::*;

  fetch_state_t state;
  if_id_t       id_q;
  logic [31:0]  pc_q;
  logic [31:0]  hold_buf;
  logic [31:0]  hold_pc;
  logic         hold_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  tgt_al;
  logic         done;
  logic         pc_load;
  logic         pc_adv;
  logic [31:0]  pc_next;

  assign imem_req  = reset;
  assign imem_addr = pc_q;
  assign done      = imem_req & ~imem_busywait;
  assign tgt_al    = branch_target & ~32'h3;

  // A redirect while the fetch is still in flight waits in SQUASH
  assign pc_load = branch_taken
                 ? (!imem_busywait || state == HELD)
                 : (state == SQUASH && done);
  assign pc_next = branch_taken ? tgt_al : redirect_pc;
  assign pc_adv  = !branch_taken && state == RUN
                 && done && pc_enable;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .target (pc_next),
    .advance(pc_adv),
    .pc_q   (pc_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      id_q        <= '{NOP_INSTR, RESET_PC, 1'b0};
      hold_buf    <= NOP_INSTR;
      hold_pc     <= RESET_PC;
      hold_valid  <= 1'b0;
      redirect_pc <= RESET_PC;
    end else if (branch_taken) begin
      id_q       <= '{NOP_INSTR, id_q.pc, 1'b0};
      hold_valid <= 1'b0;
      if (!imem_busywait || state == HELD) begin
        state <= RUN;
      end else begin
        state       <= SQUASH;
        redirect_pc <= tgt_al;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (done && !busywait_IF_ID) begin
            id_q <= '{imem_rdata, pc_q, 1'b1};
          end else if (done) begin
            hold_buf   <= imem_rdata;
            hold_pc    <= pc_q;
            hold_valid <= 1'b1;
            state      <= HELD;
          end else if (!busywait_IF_ID) begin
            id_q <= '{NOP_INSTR, id_q.pc, 1'b0};
          end
        end
        HELD: begin
          if (!busywait_IF_ID && hold_valid) begin
            id_q       <= '{hold_buf, hold_pc, 1'b1};
            hold_valid <= 1'b0;
            state      <= RUN;
          end
        end
        SQUASH: begin
          if (done) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign instruction = id_q.instr;
  assign pc_ID       = id_q.pc;
  assign pc_plus4_ID = id_q.pc + 32'd4;
  assign valid_ID    = id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a
// transaction-level fetch model.
module tb_if_stage;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_enable;
  logic        busywait_IF_ID;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busywait;
  logic [31:0] instruction;
  logic [31:0] pc_ID;
  logic [31:0] pc_plus4_ID;
  logic        valid_ID;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } held_t;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic        m_valid;
  logic        m_req;
  logic        m_discard;
  logic [31:0] m_redir;
  held_t       held[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc_enable     (pc_enable),
    .busywait_IF_ID(busywait_IF_ID),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_busywait (imem_busywait),
    .instruction   (instruction),
    .pc_ID         (pc_ID),
    .pc_plus4_ID   (pc_plus4_ID),
    .valid_ID      (valid_ID)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_instr   = NOP_INSTR;
    m_pcid    = RESET_PC;
    m_valid   = 1'b0;
    m_discard = 1'b0;
    m_redir   = RESET_PC;
    held.delete();
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".addr"},  imem_addr, m_pc);
    chk({ph, ".req"},   {31'd0, imem_req}, {31'd0, m_req});
    chk({ph, ".instr"}, instruction, m_instr);
    chk({ph, ".pc"},    pc_ID, m_pcid);
    chk({ph, ".pc4"},   pc_plus4_ID, m_pcid + 32'd4);
    chk({ph, ".valid"}, {31'd0, valid_ID}, {31'd0, m_valid});
  endtask

  // One clock of stimulus; the model advances by the fetch rules
  task automatic step(input string ph, input logic bw,
                      input logic bwid, input logic pce,
                      input logic bt, input logic [31:0] tgt);
    logic [31:0] t;
    logic [31:0] w;
    imem_busywait  = bw;
    busywait_IF_ID = bwid;
    pc_enable      = pce;
    branch_taken   = bt;
    branch_target  = tgt;
    t = {tgt[31:2], 2'b00};
    w = mem_word(m_pc);
    if (bt) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
      if (!bw || held.size() != 0) begin
        m_pc      = t;
        m_discard = 1'b0;
      end else begin
        m_discard = 1'b1;
        m_redir   = t;
      end
      held.delete();
    end else if (m_discard) begin
      if (!bw) begin
        m_pc      = m_redir;
        m_discard = 1'b0;
      end
    end else if (held.size() != 0) begin
      if (!bwid) begin
        m_instr = held[0].w;
        m_pcid  = held[0].pc;
        m_valid = 1'b1;
        held.delete();
      end
    end else if (!bw) begin
      if (bwid) begin
        held.push_back('{w, m_pc});
      end else begin
        m_instr = w;
        m_pcid  = m_pc;
        m_valid = 1'b1;
      end
      if (pce) m_pc = m_pc + 32'd4;
    end else if (!bwid) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    reset          = 1'b0;
    pc_enable      = 1'b0;
    busywait_IF_ID = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    imem_busywait  = 1'b0;
    m_req          = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 1'b1;
    m_req = 1'b1;

    repeat (3) step("t1", 0, 0, 1, 0, 0);
    repeat (3) step("t2w", 1, 0, 1, 0, 0);
    step("t2", 0, 0, 1, 0, 0);
    repeat (2) step("t3h", 0, 1, 0, 0, 0);
    repeat (2) step("t3", 0, 0, 1, 0, 0);
    step("t4b", 1, 0, 1, 1, 32'h100);
    step("t4s", 1, 0, 1, 0, 0);
    repeat (2) step("t4", 0, 0, 1, 0, 0);
    step("t5b", 0, 1, 1, 1, 32'h200);
    repeat (2) step("t5", 0, 0, 1, 0, 0);
    step("t6b", 0, 0, 1, 1, 32'hFFFF_FFFE);
    repeat (3) step("t6", 0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           ($urandom % 10) < 3,
           ($urandom % 10) < 3,
           ($urandom % 10) < 8,
           ($urandom % 16) == 0,
           $urandom);
    end

    #2 reset = 1'b0;
    #1;
    m_req = 1'b0;
    model_reset();
    compare_all("midrst");
    @(negedge clk);
    reset = 1'b1;
    m_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step("rnd2",
           ($urandom % 10) < 3,
           ($urandom % 10) < 3,
           ($urandom % 10) < 8,
           ($urandom % 12) == 0,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
